// File: rtl/sound_pkg.sv
// Shared types, sizes and sound ids for the sound sequencer.
// Note-table entries are packed so the ROM can return a whole note per read.
package sound_pkg;

    localparam int NUM_SOUNDS      = 4;
    localparam int NOTES_PER_SOUND = 8;
    localparam int PRESCALE_W      = 10;
    localparam int DUR_W           = 6;
    localparam int ID_W            = $clog2(NUM_SOUNDS);
    localparam int IDX_W           = $clog2(NOTES_PER_SOUND);
    localparam int ADDR_W          = ID_W + IDX_W;

    localparam logic [ID_W-1:0] SND_SHOT    = ID_W'(0);
    localparam logic [ID_W-1:0] SND_EXPLODE = ID_W'(1);
    localparam logic [ID_W-1:0] SND_STEP    = ID_W'(2);
    localparam logic [ID_W-1:0] SND_UFO     = ID_W'(3);

    typedef struct packed {
        logic                  last;
        logic                  rest;
        logic [PRESCALE_W-1:0] prescale;
        logic [DUR_W-1:0]      duration;
    } note_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY
    } state_t;

    function automatic logic [ID_W-1:0] lowest_set(
        input logic [NUM_SOUNDS-1:0] v
    );
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    function automatic note_entry_t mk_note(
        input logic                  last,
        input logic                  rest,
        input logic [PRESCALE_W-1:0] pre,
        input logic [DUR_W-1:0]      dur
    );
        note_entry_t n;
        n.last     = last;
        n.rest     = rest;
        n.prescale = pre;
        n.duration = dur;
        return n;
    endfunction

endpackage

// File: rtl/sound_note_rom.sv
// Melody tables for all sounds, one registered read per clock.
// Unused slots read back as a terminating rest.
module sound_note_rom
    import sound_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output note_entry_t       data
);

    note_entry_t entry;

    always_comb begin
        entry = mk_note(1'b1, 1'b1, 10'd0, 6'd1);
        case (addr)
            {SND_SHOT, 3'd0}:    entry = mk_note(1'b0, 1'b0, 10'd500, 6'd1);
            {SND_SHOT, 3'd1}:    entry = mk_note(1'b0, 1'b0, 10'd450, 6'd1);
            {SND_SHOT, 3'd2}:    entry = mk_note(1'b1, 1'b0, 10'd400, 6'd0);
            // Explosion runs the full table and ends on the last slot.
            {SND_EXPLODE, 3'd0}: entry = mk_note(1'b0, 1'b0, 10'd100, 6'd1);
            {SND_EXPLODE, 3'd1}: entry = mk_note(1'b0, 1'b0, 10'd120, 6'd2);
            {SND_EXPLODE, 3'd2}: entry = mk_note(1'b0, 1'b0, 10'd140, 6'd1);
            {SND_EXPLODE, 3'd3}: entry = mk_note(1'b0, 1'b1, 10'd160, 6'd2);
            {SND_EXPLODE, 3'd4}: entry = mk_note(1'b0, 1'b0, 10'd180, 6'd1);
            {SND_EXPLODE, 3'd5}: entry = mk_note(1'b0, 1'b0, 10'd200, 6'd1);
            {SND_EXPLODE, 3'd6}: entry = mk_note(1'b0, 1'b0, 10'd220, 6'd2);
            {SND_EXPLODE, 3'd7}: entry = mk_note(1'b0, 1'b0, 10'd240, 6'd1);
            {SND_STEP, 3'd0}:    entry = mk_note(1'b0, 1'b0, 10'd249, 6'd2);
            {SND_STEP, 3'd1}:    entry = mk_note(1'b0, 1'b0, 10'd199, 6'd2);
            {SND_STEP, 3'd2}:    entry = mk_note(1'b1, 1'b0, 10'd166, 6'd2);
            {SND_UFO, 3'd0}:     entry = mk_note(1'b0, 1'b0, 10'd300, 6'd3);
            {SND_UFO, 3'd1}:     entry = mk_note(1'b0, 1'b1, 10'd310, 6'd2);
            {SND_UFO, 3'd2}:     entry = mk_note(1'b0, 1'b0, 10'd320, 6'd0);
            {SND_UFO, 3'd3}:     entry = mk_note(1'b1, 1'b0, 10'd330, 6'd1);
            default:             ;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= entry;
    end

endmodule

// File: rtl/sound_sequencer.sv
// Priority arbiter and note sequencer driving the sound prescaler.
// Lower sound ids preempt higher ones; equal or lower priority requests wait.
module sound_sequencer
    import sound_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SOUNDS-1:0] sound_req,
    input  logic                  tick,
    input  logic                  mute,
    output logic [PRESCALE_W-1:0] preScaleValue,
    output logic                  tone_en,
    output logic                  busy,
    output logic [ID_W-1:0]       active_sound,
    output logic                  sound_done
);

    state_t                  state, state_n;
    logic [NUM_SOUNDS-1:0]   pending, pending_n, pend_clr;
    logic [NUM_SOUNDS-1:0]   req_q, req_rise;
    logic [IDX_W-1:0]        note_idx, note_idx_n;
    logic [DUR_W-1:0]        dur_cnt, dur_cnt_n;
    logic                    tone_on, tone_on_n;
    logic                    note_last, note_last_n;
    logic [PRESCALE_W-1:0]   pre_n;
    logic [ID_W-1:0]         active_n, pick;
    logic                    done_n, preempt;
    note_entry_t             rom_data;

    sound_note_rom u_rom (
        .clk  (clk),
        .addr ({active_sound, note_idx}),
        .data (rom_data)
    );

    assign req_rise = sound_req & ~req_q;
    assign busy     = (state != IDLE);
    assign pick     = lowest_set(pending);
    assign preempt  = busy && (|pending) && (pick < active_sound);

    always_comb begin
        state_n     = state;
        pend_clr    = '0;
        active_n    = active_sound;
        note_idx_n  = note_idx;
        dur_cnt_n   = dur_cnt;
        pre_n       = preScaleValue;
        tone_on_n   = tone_on;
        note_last_n = note_last;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    active_n   = pick;
                    note_idx_n = '0;
                    pend_clr   = NUM_SOUNDS'(1) << pick;
                    state_n    = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                pre_n       = rom_data.prescale;
                tone_on_n   = !rom_data.rest;
                note_last_n = rom_data.last;
                dur_cnt_n   = (rom_data.duration == '0)
                            ? DUR_W'(1) : rom_data.duration;
                state_n     = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    if (dur_cnt == DUR_W'(1)) begin
                        if (note_last ||
                            note_idx == IDX_W'(NOTES_PER_SOUND - 1)) begin
                            tone_on_n = 1'b0;
                            done_n    = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            note_idx_n = note_idx + IDX_W'(1);
                            state_n    = FETCH;
                        end
                    end else begin
                        dur_cnt_n = dur_cnt - DUR_W'(1);
                    end
                end
            end
        endcase
        // Abort keeps the current tone sounding until the new note loads.
        if (preempt) begin
            active_n    = pick;
            note_idx_n  = '0;
            pend_clr    = NUM_SOUNDS'(1) << pick;
            state_n     = FETCH;
            done_n      = 1'b0;
            tone_on_n   = tone_on;
            pre_n       = preScaleValue;
            dur_cnt_n   = dur_cnt;
            note_last_n = note_last;
        end
        pending_n = (pending & ~pend_clr) | req_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            req_q         <= '0;
            note_idx      <= '0;
            dur_cnt       <= '0;
            tone_on       <= 1'b0;
            note_last     <= 1'b0;
            preScaleValue <= '0;
            tone_en       <= 1'b0;
            active_sound  <= '0;
            sound_done    <= 1'b0;
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            req_q         <= sound_req;
            note_idx      <= note_idx_n;
            dur_cnt       <= dur_cnt_n;
            tone_on       <= tone_on_n;
            note_last     <= note_last_n;
            preScaleValue <= pre_n;
            tone_en       <= tone_on_n && !mute;
            active_sound  <= active_n;
            sound_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed and randomized bench for sound_sequencer with a note-level model.
// The model tracks playback as a countdown of setup cycles and remaining ticks.
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sound_req;
    logic       tick;
    logic       mute;
    logic [9:0] preScaleValue;
    logic       tone_en;
    logic       busy;
    logic [1:0] active_sound;
    logic       sound_done;

    always #5 clk = ~clk;

    sound_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sound_req     (sound_req),
        .tick          (tick),
        .mute          (mute),
        .preScaleValue (preScaleValue),
        .tone_en       (tone_en),
        .busy          (busy),
        .active_sound  (active_sound),
        .sound_done    (sound_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    int t_pre [32];
    int t_dur [32];
    bit t_rest [32];
    bit t_last [32];

    bit [3:0] m_pend, m_prev;
    bit m_busy, m_tone_note, m_tone_en, m_done, m_last;
    int m_id, m_idx, m_setup, m_left, m_pre;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic set_note(input int a, input int pre, input int dur,
                            input bit rest, input bit last);
        t_pre[a] = pre;
        t_dur[a] = dur;
        t_rest[a] = rest;
        t_last[a] = last;
    endtask

    task automatic init_table();
        for (int a = 0; a < 32; a++) set_note(a, 0, 1, 1'b1, 1'b1);
        set_note(0, 500, 1, 0, 0);
        set_note(1, 450, 1, 0, 0);
        set_note(2, 400, 0, 0, 1);
        set_note(8, 100, 1, 0, 0);
        set_note(9, 120, 2, 0, 0);
        set_note(10, 140, 1, 0, 0);
        set_note(11, 160, 2, 1, 0);
        set_note(12, 180, 1, 0, 0);
        set_note(13, 200, 1, 0, 0);
        set_note(14, 220, 2, 0, 0);
        set_note(15, 240, 1, 0, 0);
        set_note(16, 249, 2, 0, 0);
        set_note(17, 199, 2, 0, 0);
        set_note(18, 166, 2, 0, 1);
        set_note(24, 300, 3, 0, 0);
        set_note(25, 310, 2, 1, 0);
        set_note(26, 320, 0, 0, 0);
        set_note(27, 330, 1, 0, 1);
    endtask

    // m_setup: 2 = waiting for the table read, 1 = note arriving, 0 = sounding
    task automatic model_edge(input bit [3:0] r, input bit t, input bit m,
                              input bit rst);
        int pick;
        int a;
        bit [3:0] rise;
        if (rst) begin
            m_pend = 0; m_prev = 0; m_busy = 0; m_tone_note = 0;
            m_tone_en = 0; m_done = 0; m_last = 0;
            m_id = 0; m_idx = 0; m_setup = 0; m_left = 0; m_pre = 0;
            return;
        end
        rise = r & ~m_prev;
        m_prev = r;
        m_done = 0;
        pick = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) pick = i;
        if (pick >= 0 && (!m_busy || pick < m_id)) begin
            m_busy = 1; m_id = pick; m_idx = 0; m_setup = 2;
            m_pend[pick] = 1'b0;
        end else if (m_busy && m_setup == 2) begin
            m_setup = 1;
        end else if (m_busy && m_setup == 1) begin
            a = m_id * 8 + m_idx;
            m_pre = t_pre[a];
            m_tone_note = !t_rest[a];
            m_left = (t_dur[a] == 0) ? 1 : t_dur[a];
            m_last = t_last[a] || (m_idx == 7);
            m_setup = 0;
        end else if (m_busy && t) begin
            if (m_left > 1) m_left--;
            else if (m_last) begin
                m_busy = 0; m_tone_note = 0; m_done = 1;
            end else begin
                m_idx++; m_setup = 2;
            end
        end
        m_pend |= rise;
        m_tone_en = m_tone_note && !m;
    endtask

    task automatic step(input bit [3:0] r, input bit t, input bit m);
        sound_req = r;
        tick = t;
        mute = m;
        @(posedge clk);
        model_edge(r, t, m, reset);
        #1;
        chk("busy", busy, m_busy);
        chk("tone_en", tone_en, m_tone_en);
        chk("prescale", preScaleValue, m_pre);
        chk("active", active_sound, m_id);
        chk("done", sound_done, m_done);
        if (sound_done === 1'b1) n_done++;
        sound_req = '0;
        tick = 1'b0;
    endtask

    task automatic wait_note(input int idx, input bit m, input string tag);
        int k;
        k = 0;
        while (!(m_busy && m_setup == 0 && m_idx == idx) && k < 200) begin
            step(4'b0000, 1'b1, m);
            k++;
        end
        if (k >= 200) chk(tag, 0, 1);
    endtask

    initial begin
        int d0;
        int k;
        bit seen199, seen166, mute_lvl;
        init_table();
        reset = 1'b1;
        sound_req = '0;
        tick = 1'b0;
        mute = 1'b0;
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("rst_busy", busy, 0);
        chk("rst_tone", tone_en, 0);
        chk("rst_pre", preScaleValue, 0);
        chk("rst_active", active_sound, 0);
        chk("rst_done", sound_done, 0);
        reset = 1'b0;

        d0 = n_done;
        for (int i = 0; i < 100; i++) step(4'b0000, (i % 10) == 0, 1'b0);
        chk("idle_done", n_done - d0, 0);
        chk("idle_busy", busy, 0);

        // Single three-note sound
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("s2_tone_pre", tone_en, 0);
        step(4'b0000, 1'b0, 1'b0);
        chk("s2_tone_rise", tone_en, 1);
        chk("s2_pre0", preScaleValue, 249);
        d0 = n_done;
        seen199 = 0;
        seen166 = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0000, (i % 2) == 0, 1'b0);
            if (preScaleValue === 10'd199) seen199 = 1;
            if (preScaleValue === 10'd166) seen166 = 1;
        end
        chk("s2_seen199", seen199, 1);
        chk("s2_seen166", seen166, 1);
        chk("s2_done_once", n_done - d0, 1);
        chk("s2_idle", busy, 0);

        // Simultaneous requests: sound 1 first, then sound 2
        d0 = n_done;
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("prio_first", active_sound, 1);
        for (int i = 0; i < 80; i++) step(4'b0000, 1'b1, 1'b0);
        chk("prio_two_done", n_done - d0, 2);
        chk("prio_last", active_sound, 2);

        // Preemption of sound 3 on its second note
        step(4'b1000, 1'b0, 1'b0);
        wait_note(1, 1'b0, "pre_wait");
        d0 = n_done;
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("pre_active", active_sound, 0);
        chk("pre_busy", busy, 1);
        chk("pre_nodone", n_done - d0, 0);
        for (int i = 0; i < 40; i++) step(4'b0000, 1'b1, 1'b0);
        chk("pre_one_done", n_done - d0, 1);
        chk("pre_no_replay", busy, 0);

        // Rest note, mute, zero-duration note
        step(4'b1000, 1'b0, 1'b0);
        wait_note(1, 1'b0, "rest_wait");
        chk("rest_tone", tone_en, 0);
        chk("rest_pre", preScaleValue, 310);
        wait_note(2, 1'b0, "mute_wait");
        chk("tone_back", tone_en, 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("mute_tone", tone_en, 0);
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("dur0_next", preScaleValue, 330);
        chk("dur0_muted", tone_en, 0);
        d0 = n_done;
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b1);
        chk("mute_done", n_done - d0, 1);

        // Replay of the playing id, then reset during the replay
        step(4'b0100, 1'b0, 1'b0);
        wait_note(1, 1'b0, "replay_wait");
        step(4'b0100, 1'b0, 1'b0);
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < 60) begin
            step(4'b0000, 1'b1, 1'b0);
            k++;
        end
        chk("replay_first_done", n_done - d0, 1);
        step(4'b0000, 1'b0, 1'b0);
        chk("replay_busy", busy, 1);
        chk("replay_id", active_sound, 2);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        step(4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pre", preScaleValue, 0);
        chk("mid_rst_tone", tone_en, 0);
        d0 = n_done;
        for (int i = 0; i < 20; i++) step(4'b0000, 1'b1, 1'b0);
        chk("mid_rst_quiet", busy, 0);
        chk("mid_rst_nodone", n_done - d0, 0);

        // Randomized traffic against the model
        mute_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] r;
            bit t;
            r = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15))
                                             : 4'b0000;
            t = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) mute_lvl = ~mute_lvl;
            reset = ($urandom_range(0, 999) == 0);
            step(r, t, mute_lvl);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Sequencer and arbiter that feeds the sound unit's clock-enable prescaler. It accepts one-cycle sound requests from game logic (shot, explosion, alien step, UFO) and picks one by fixed priority. It steps through that sound's note table, driving the prescaler's preScaleValue and a tone enable, and holds each note for a programmed number of 1 ms ticks.

Parameters:
NUM_SOUNDS, 4, number of requesters/sound tables; index 0 is highest priority
NOTES_PER_SOUND, 8, table entries per sound
PRESCALE_W, 10, width of preScaleValue driven to the prescaler
DUR_W, 6, note duration field width, in tick units

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sound_req  in  NUM_SOUNDS  one-cycle request pulses, one bit per sound
tick  in  1  1 kHz single-cycle enable, used as the duration time base
mute  in  1  level; forces tone_en low without stopping sequencing
preScaleValue  out  PRESCALE_W  divider value to the prescaler
tone_en  out  1  high while a non-rest note plays and mute is low
busy  out  1  high in any state other than IDLE
active_sound  out  $clog2(NUM_SOUNDS)  id of the sound being played
sound_done  out  1  one-cycle pulse when a sound completes normally

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: preScaleValue=0, tone_en=0, busy=0, active_sound=0, sound_done=0, pending=0, note_idx=0, dur_cnt=0, state=IDLE. Reset mid-note aborts immediately with no sound_done.
- Pending latch:
  - Rising sound_req[i] sets pending[i].
  - pending[i] clears in the cycle sound i is accepted.
  - A new request in that same cycle wins, so pending stays set and the sound replays once afterwards.
- Note entry fields: last (1b), rest (1b), prescale (PRESCALE_W), duration (DUR_W). A duration of 0 is treated as 1.
- sound_note_rom has 1-cycle registered read latency. Address = {sound id, note_idx}.
- States:
  - IDLE: if pending≠0, accept the lowest set index, set active_sound, note_idx=0, go to FETCH. Otherwise stay.
  - FETCH: ROM address presented; go to LOAD.
  - LOAD: preScaleValue<=prescale; tone_en<=!rest && !mute; dur_cnt<=max(duration,1); go to PLAY.
  - PLAY: each tick decrements dur_cnt.
    - On tick with dur_cnt==1 and (last or note_idx==NOTES_PER_SOUND-1): tone_en<=0, sound_done pulses for 1 cycle, go to IDLE.
    - On tick with dur_cnt==1 otherwise: note_idx+1, go to FETCH.
- Between notes (FETCH/LOAD), preScaleValue and tone_en hold their previous values, so there is no audible gap.
- Latency: a request sampled at edge E0 in IDLE gives pending at E0, FETCH at E1, LOAD at E2. preScaleValue/tone_en are valid after E3 (3 clocks). A back-to-back pending sound starts 1 cycle after sound_done (IDLE→FETCH).
- Preemption:
  - In FETCH, LOAD or PLAY, if any pending[j] has j < active_sound, abort the current sound with no sound_done.
  - Accept j (clear pending[j]), note_idx=0, go to FETCH. tone_en holds until the new note loads.
  - Equal or lower priority requests wait in pending.
  - A request for the currently playing id is pended and replays after completion.
- mute: sampled each cycle. tone_en = note_is_tone && !mute, registered with 1-cycle delay. Durations keep counting while muted.
- Tick gating: tick is ignored outside PLAY, and a tick in the same cycle as LOAD is not counted.

Decomposition:
- Package sound_pkg holds:
  - note_entry_t packed struct {last, rest, prescale, duration}
  - state_t enum {IDLE, FETCH, LOAD, PLAY}
  - NUM_SOUNDS, NOTES_PER_SOUND, PRESCALE_W, DUR_W
  - named sound-id constants: SND_SHOT=0, SND_EXPLODE=1, SND_STEP=2, SND_UFO=3
- Sub-module sound_note_rom: case-based table with a registered output. Keeping it separate lets the melody tables change without touching the FSM.

Test Plan:
- Reset then idle: no requests for 100 cycles → busy=0, tone_en=0, preScaleValue=0, sound_done never asserts.
- Single sound: pulse sound_req=4'b0100 where the table is 3 notes (prescale 249/199/166, duration 2 each, last on note 2) → tone_en rises 3 clocks after the request; preScaleValue steps 249→199→166 after every 2 ticks; sound_done pulses once after the 6th tick; busy falls the same cycle.
- Priority on simultaneous requests: sound_req=4'b0110 in one cycle → sound 1 plays fully and sound_done pulses; sound 2 enters FETCH 1 cycle later; active_sound goes 1 then 2.
- Preemption: sound 3 in PLAY on note 1, pulse sound_req[0] → next cycle FETCH with active_sound=0, no sound_done for sound 3, pending[3]=0.
- Rest and mute: a rest-flagged note gives tone_en=0 while preScaleValue still loads. mute=1 mid-note → tone_en=0 one cycle later; the note still advances on schedule. A duration=0 entry lasts exactly 1 tick.
- Reset mid-operation plus replay: request sound 2 again while it plays → it replays after sound_done. Assert reset during the replay → all outputs return to reset values next cycle and pending clears.
